flood_fill_engine: RTL and testbench

Sequential flood-fill engine between the color selector and the board store feeding the VGA display. On a START request it grows the flooded region from cell (0,0) over the current board, then recolours that region to the selected color. It then checks whether the whole board is one color. The board lives in an external synchronous RAM that this block reads and writes one cell per cycle. The flood mask is held in internal flops.

---
 rtl/flood_fill_engine.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_flood_fill_engine.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flood_fill_engine.sv
// -----------------------------------------------------------------------------
// flood_fill_engine
//
// One move of the flood-it game. On START the engine grows the region that is
// connected to cell (0,0) and has the same color as (0,0), repaints that region
// to NEW_COLOR, and then scans the board to see whether it is a single color.
// The board lives in an external synchronous RAM: one read or one write per
// cycle, read data returned one cycle after the address. The flood mask is kept
// in internal flops.
//
// Parameters
//   MAX_SIZE      largest board dimension supported (SIZE is clamped to it)
//   COLOR_W       bits per cell color
//
// Ports
//   CLOCK         system clock
//   RESET_N       synchronous active-low reset
//   START         move request, accepted only in IDLE
//   SIZE          board dimension, sampled when START is accepted
//   NEW_COLOR     selected color, sampled when START is accepted
//   BUSY          high from the cycle after acceptance until DONE
//   DONE          one-cycle completion pulse
//   CHANGED       NEW_COLOR differed from the old (0,0) color (held)
//   WON           whole board equals NEW_COLOR after the move (held)
//   REGION_COUNT  number of cells in the flooded region (held)
//   RD_ROW/RD_COL board read address
//   RD_DATA       board read data, one cycle after the address
//   WR_EN         board write strobe
//   WR_ROW/WR_COL board write address
//   WR_DATA       board write data
// -----------------------------------------------------------------------------
module flood_fill_engine #(
  parameter int MAX_SIZE = 26,
  parameter int COLOR_W  = 3
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic [4:0]         SIZE,
  input  logic [COLOR_W-1:0] NEW_COLOR,
  output logic               BUSY,
  output logic               DONE,
  output logic               CHANGED,
  output logic               WON,
  output logic [9:0]         REGION_COUNT,
  output logic [4:0]         RD_ROW,
  output logic [4:0]         RD_COL,
  input  logic [COLOR_W-1:0] RD_DATA,
  output logic               WR_EN,
  output logic [4:0]         WR_ROW,
  output logic [4:0]         WR_COL,
  output logic [COLOR_W-1:0] WR_DATA
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SEED     = 3'd1;
  localparam logic [2:0] ST_GROW     = 3'd2;
  localparam logic [2:0] ST_GROW_CHK = 3'd3;
  localparam logic [2:0] ST_PAINT    = 3'd4;
  localparam logic [2:0] ST_VERIFY   = 3'd5;
  localparam logic [2:0] ST_FIN      = 3'd6;

  localparam logic [4:0] MAX_N = 5'(MAX_SIZE);

  // Clamp the requested dimension into 1..MAX_SIZE.
  function automatic logic [4:0] clamp_size(input logic [4:0] s);
    logic [4:0] r;
    if (s == 5'd0) begin
      r = 5'd1;
    end else if (s > MAX_N) begin
      r = MAX_N;
    end else begin
      r = s;
    end
    return r;
  endfunction

  // Next raster position {row, col} after (row, col) on a board whose last
  // index is 'last'. Only called when (row, col) is not the final cell.
  function automatic logic [9:0] raster_next(input logic [4:0] row,
                                             input logic [4:0] col,
                                             input logic [4:0] last);
    logic [9:0] r;
    if (col == last) begin
      r = {row + 5'd1, 5'd0};
    end else begin
      r = {row, col + 5'd1};
    end
    return r;
  endfunction

  // Control and datapath registers
  logic [2:0]         state_r;
  logic [4:0]         n_r;
  logic [COLOR_W-1:0] new_color_r;
  logic [COLOR_W-1:0] old_color_r;
  logic               changed_r;
  logic               added_r;
  logic               won_acc_r;
  logic [9:0]         count_r;
  logic               seed_ph_r;

  // Read pipeline: rd_vld_r marks a live address on RD_ROW/RD_COL this cycle,
  // pend_* names the cell whose data is on RD_DATA this cycle.
  logic               rd_vld_r;
  logic               pend_vld_r;
  logic [4:0]         pend_row_r;
  logic [4:0]         pend_col_r;

  logic [MAX_SIZE-1:0] mask_r [MAX_SIZE];

  // Combinational helpers
  logic [4:0]  last_s;
  logic        rd_last_s;
  logic        wr_last_s;
  logic [9:0]  rd_next_s;
  logic [9:0]  wr_next_s;
  logic        pass_end_s;
  logic        up_ok_s;
  logic        dn_ok_s;
  logic        lf_ok_s;
  logic        rt_ok_s;
  logic [4:0]  row_up_s;
  logic [4:0]  row_dn_s;
  logic [4:0]  col_lf_s;
  logic [4:0]  col_rt_s;
  logic        nbr_hit_s;
  logic        grow_join_s;
  logic        mask_clr_s;
  logic        mask_seed_s;
  logic        wr_next_mask_s;

  // Raster bookkeeping for the read and write scans
  always_comb begin
    last_s     = n_r - 5'd1;
    rd_last_s  = (RD_ROW == last_s) && (RD_COL == last_s);
    wr_last_s  = (WR_ROW == last_s) && (WR_COL == last_s);
    rd_next_s  = raster_next(RD_ROW, RD_COL, last_s);
    wr_next_s  = raster_next(WR_ROW, WR_COL, last_s);
    // The final data of a pass is on RD_DATA once no more addresses are live.
    pass_end_s = pend_vld_r && !rd_vld_r;
    if (wr_last_s) begin
      wr_next_mask_s = 1'b0;
    end else begin
      wr_next_mask_s = mask_r[wr_next_s[9:5]][wr_next_s[4:0]];
    end
  end

  // Neighbour test for the cell whose data is arriving. Out-of-board indices
  // are folded back onto the cell itself so the array is never over-indexed;
  // the *_ok_s flags discard those lookups.
  always_comb begin
    up_ok_s  = (pend_row_r != 5'd0);
    dn_ok_s  = (pend_row_r != last_s);
    lf_ok_s  = (pend_col_r != 5'd0);
    rt_ok_s  = (pend_col_r != last_s);
    row_up_s = up_ok_s ? (pend_row_r - 5'd1) : pend_row_r;
    row_dn_s = dn_ok_s ? (pend_row_r + 5'd1) : pend_row_r;
    col_lf_s = lf_ok_s ? (pend_col_r - 5'd1) : pend_col_r;
    col_rt_s = rt_ok_s ? (pend_col_r + 5'd1) : pend_col_r;
    nbr_hit_s = (up_ok_s && mask_r[row_up_s][pend_col_r]) ||
                (dn_ok_s && mask_r[row_dn_s][pend_col_r]) ||
                (lf_ok_s && mask_r[pend_row_r][col_lf_s]) ||
                (rt_ok_s && mask_r[pend_row_r][col_rt_s]);
    grow_join_s = (state_r == ST_GROW) && pend_vld_r &&
                  !mask_r[pend_row_r][pend_col_r] &&
                  (RD_DATA == old_color_r) && nbr_hit_s;
    mask_clr_s  = (state_r == ST_IDLE) && START;
    mask_seed_s = (state_r == ST_SEED) && seed_ph_r;
  end

  // Flood mask: cleared on reset and on acceptance, seeded at (0,0), grown on joins
  always_ff @(posedge CLOCK) begin
    if (!RESET_N || mask_clr_s) begin
      mask_r <= '{default: {MAX_SIZE{1'b0}}};
    end else if (mask_seed_s) begin
      mask_r[5'd0][5'd0] <= 1'b1;
    end else if (grow_join_s) begin
      mask_r[pend_row_r][pend_col_r] <= 1'b1;
    end
  end

  // Move sequencer: accept, seed, grow passes, paint, verify, report
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_r      <= ST_IDLE;
      n_r          <= 5'd0;
      new_color_r  <= {COLOR_W{1'b0}};
      old_color_r  <= {COLOR_W{1'b0}};
      changed_r    <= 1'b0;
      added_r      <= 1'b0;
      won_acc_r    <= 1'b0;
      count_r      <= 10'd0;
      seed_ph_r    <= 1'b0;
      rd_vld_r     <= 1'b0;
      pend_vld_r   <= 1'b0;
      pend_row_r   <= 5'd0;
      pend_col_r   <= 5'd0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      CHANGED      <= 1'b0;
      WON          <= 1'b0;
      REGION_COUNT <= 10'd0;
      RD_ROW       <= 5'd0;
      RD_COL       <= 5'd0;
      WR_EN        <= 1'b0;
      WR_ROW       <= 5'd0;
      WR_COL       <= 5'd0;
      WR_DATA      <= {COLOR_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            n_r         <= clamp_size(SIZE);
            new_color_r <= NEW_COLOR;
            seed_ph_r   <= 1'b0;
            RD_ROW      <= 5'd0;
            RD_COL      <= 5'd0;
            BUSY        <= 1'b1;
            state_r     <= ST_SEED;
          end
        end

        // First cycle presents (0,0); second cycle captures its color.
        ST_SEED: begin
          if (!seed_ph_r) begin
            seed_ph_r <= 1'b1;
          end else begin
            old_color_r <= RD_DATA;
            changed_r   <= (new_color_r != RD_DATA);
            count_r     <= 10'd1;
            added_r     <= 1'b0;
            RD_ROW      <= 5'd0;
            RD_COL      <= 5'd0;
            rd_vld_r    <= 1'b1;
            state_r     <= ST_GROW;
          end
        end

        // Both passes issue one read per cycle and consume data one cycle later.
        ST_GROW, ST_VERIFY: begin
          pend_vld_r <= rd_vld_r;
          pend_row_r <= RD_ROW;
          pend_col_r <= RD_COL;
          if (rd_vld_r) begin
            if (rd_last_s) begin
              rd_vld_r <= 1'b0;
            end else begin
              RD_ROW <= rd_next_s[9:5];
              RD_COL <= rd_next_s[4:0];
            end
          end
          if (state_r == ST_GROW) begin
            if (grow_join_s) begin
              count_r <= count_r + 10'd1;
              added_r <= 1'b1;
            end
            if (pass_end_s) begin
              state_r <= ST_GROW_CHK;
            end
          end else begin
            if (pend_vld_r && (RD_DATA != new_color_r)) begin
              won_acc_r <= 1'b0;
            end
            if (pass_end_s) begin
              // The last cell's comparison arrives in this same cycle.
              WON          <= won_acc_r && (RD_DATA == new_color_r);
              CHANGED      <= changed_r;
              REGION_COUNT <= count_r;
              DONE         <= 1'b1;
              BUSY         <= 1'b0;
              state_r      <= ST_FIN;
            end
          end
        end

        // Another pass is needed whenever the last one added a cell, since a
        // cell can be reached through a neighbour scanned after it.
        ST_GROW_CHK: begin
          if (added_r) begin
            added_r  <= 1'b0;
            RD_ROW   <= 5'd0;
            RD_COL   <= 5'd0;
            rd_vld_r <= 1'b1;
            state_r  <= ST_GROW;
          end else if (changed_r) begin
            WR_ROW  <= 5'd0;
            WR_COL  <= 5'd0;
            WR_EN   <= mask_r[5'd0][5'd0];
            WR_DATA <= new_color_r;
            state_r <= ST_PAINT;
          end else begin
            RD_ROW    <= 5'd0;
            RD_COL    <= 5'd0;
            rd_vld_r  <= 1'b1;
            won_acc_r <= 1'b1;
            state_r   <= ST_VERIFY;
          end
        end

        // One cell per cycle; the strobe is raised only on masked cells.
        ST_PAINT: begin
          if (wr_last_s) begin
            WR_EN     <= 1'b0;
            RD_ROW    <= 5'd0;
            RD_COL    <= 5'd0;
            rd_vld_r  <= 1'b1;
            won_acc_r <= 1'b1;
            state_r   <= ST_VERIFY;
          end else begin
            WR_ROW <= wr_next_s[9:5];
            WR_COL <= wr_next_s[4:0];
            WR_EN  <= wr_next_mask_s;
          end
        end

        ST_FIN: begin
          DONE    <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          BUSY     <= 1'b0;
          DONE     <= 1'b0;
          WR_EN    <= 1'b0;
          rd_vld_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flood_fill_engine.sv
// -----------------------------------------------------------------------------
// tb_flood_fill_engine
//
// Directed bench for flood_fill_engine with a behavioural synchronous board RAM.
// Each move pushes its expected writes and its expected completion record into
// queues; a monitor on the falling edge pops and compares them as WR_EN and
// DONE appear, and also measures START-to-DONE latency.
// -----------------------------------------------------------------------------
module tb_flood_fill_engine;

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       START = 1'b0;
  logic [4:0] SIZE = 5'd0;
  logic [2:0] NEW_COLOR = 3'd0;
  logic       BUSY;
  logic       DONE;
  logic       CHANGED;
  logic       WON;
  logic [9:0] REGION_COUNT;
  logic [4:0] RD_ROW;
  logic [4:0] RD_COL;
  logic [2:0] RD_DATA;
  logic       WR_EN;
  logic [4:0] WR_ROW;
  logic [4:0] WR_COL;
  logic [2:0] WR_DATA;

  flood_fill_engine #(.MAX_SIZE(26), .COLOR_W(3)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START), .SIZE(SIZE),
    .NEW_COLOR(NEW_COLOR), .BUSY(BUSY), .DONE(DONE), .CHANGED(CHANGED),
    .WON(WON), .REGION_COUNT(REGION_COUNT), .RD_ROW(RD_ROW), .RD_COL(RD_COL),
    .RD_DATA(RD_DATA), .WR_EN(WR_EN), .WR_ROW(WR_ROW), .WR_COL(WR_COL),
    .WR_DATA(WR_DATA)
  );

  always #5 CLOCK = ~CLOCK;

  // Board RAM with a bench-side load port
  logic [2:0] mem [32][32];
  logic       ld_en = 1'b0;
  logic       ld_all = 1'b0;
  logic [4:0] ld_row = 5'd0;
  logic [4:0] ld_col = 5'd0;
  logic [2:0] ld_data = 3'd0;

  always @(posedge CLOCK) begin
    if (ld_all) begin
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 32; c++)
          mem[r][c] <= ld_data;
    end else if (ld_en) begin
      mem[ld_row][ld_col] <= ld_data;
    end else if (WR_EN) begin
      mem[WR_ROW][WR_COL] <= WR_DATA;
    end
    RD_DATA <= mem[RD_ROW][RD_COL];
  end

  // Scoreboard
  typedef struct { int row; int col; int data; } wr_t;
  typedef struct { int chg; int won; int cnt; int lat; } done_t;
  wr_t   wr_q[$];
  done_t done_q[$];
  wr_t   we;
  done_t de;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: latency tracking plus write and completion comparisons
  int lat_cnt = 0;
  bit in_flight = 1'b0;
  always @(negedge CLOCK) begin
    if (!RESET_N) begin
      in_flight = 1'b0;
    end else if (in_flight) begin
      lat_cnt++;
    end else if (START && !BUSY) begin
      in_flight = 1'b1;
      lat_cnt = 0;
    end
    if (WR_EN) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        we = wr_q.pop_front();
        check("wr_row", int'(WR_ROW), we.row);
        check("wr_col", int'(WR_COL), we.col);
        check("wr_data", int'(WR_DATA), we.data);
      end
    end
    if (DONE) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        de = done_q.pop_front();
        check("changed", int'(CHANGED), de.chg);
        check("won", int'(WON), de.won);
        check("region_count", int'(REGION_COUNT), de.cnt);
        check("latency", lat_cnt, de.lat);
        check("busy_at_done", int'(BUSY), 0);
        check("writes_missing", wr_q.size(), 0);
      end
      in_flight = 1'b0;
    end
  end

  // Small board and expected mask, raster order, first n*n entries used
  int brd [16];
  int msk [16];

  task automatic fill_board(input int color);
    @(posedge CLOCK); #1;
    ld_all = 1'b1; ld_data = 3'(color);
    @(posedge CLOCK); #1;
    ld_all = 1'b0;
  endtask

  task automatic load_small(input int n);
    for (int i = 0; i < n * n; i++) begin
      @(posedge CLOCK); #1;
      ld_en = 1'b1; ld_row = 5'(i / n); ld_col = 5'(i % n); ld_data = 3'(brd[i]);
    end
    @(posedge CLOCK); #1;
    ld_en = 1'b0;
  endtask

  task automatic push_wr(input int r, input int c, input int d);
    wr_t w;
    w.row = r; w.col = c; w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic push_small_writes(input int n, input int color);
    for (int i = 0; i < n * n; i++)
      if (msk[i] != 0) push_wr(i / n, i % n, color);
  endtask

  task automatic push_done(input int chg, input int won, input int cnt, input int lat);
    done_t d;
    d.chg = chg; d.won = won; d.cnt = cnt; d.lat = lat;
    done_q.push_back(d);
  endtask

  // Wait for DONE with a cycle budget; optionally pulse START while busy.
  task automatic wait_done(input int glitch_at);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 6000 && !got; c++) begin
      @(negedge CLOCK);
      START = (glitch_at > 0 && c == glitch_at) ? 1'b1 : 1'b0;
      if (DONE) got = 1'b1;
    end
    START = 1'b0;
    if (!got) check("done_timeout", 0, 1);
    @(posedge CLOCK); #1;
  endtask

  task automatic run_move(input int size, input int color, input int glitch_at);
    @(posedge CLOCK); #1;
    SIZE = 5'(size); NEW_COLOR = 3'(color); START = 1'b1;
    @(posedge CLOCK); #1;
    START = 1'b0;
    wait_done(glitch_at);
  endtask

  task automatic set_test_a();
    brd = '{0,0,1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    msk = '{1,1,0,1, 0,0,0,0, 0,0,0,0, 0,0,0,0};
  endtask

  task automatic set_spiral();
    brd = '{2,2,2,2, 0,0,0,2, 2,2,0,2, 2,2,2,2};
    msk = '{1,1,1,1, 0,0,0,1, 1,1,0,1, 1,1,1,1};
  endtask

  initial begin
    // Reset held two cycles with START high
    RESET_N = 1'b0; START = 1'b1; SIZE = 5'd4; NEW_COLOR = 3'd5;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_wr_en", int'(WR_EN), 0);
    check("rst_flags", int'({CHANGED, WON}), 0);
    check("rst_count", int'(REGION_COUNT), 0);
    check("rst_rd_addr", int'({RD_ROW, RD_COL}), 0);
    check("rst_wr_bus", int'({WR_ROW, WR_COL, WR_DATA}), 0);
    @(posedge CLOCK); #1;
    START = 1'b0; RESET_N = 1'b1;
    @(negedge CLOCK);
    check("idle_after_reset", int'(BUSY), 0);

    // N=2 basic move
    fill_board(7);
    set_test_a(); load_small(2);
    push_small_writes(2, 1); push_done(1, 1, 3, 24);
    run_move(2, 1, 0);

    // N=4 spiral needing leftward/upward growth: six grow passes
    fill_board(0);
    set_spiral(); load_small(4);
    push_small_writes(4, 5); push_done(1, 0, 12, 144);
    run_move(4, 5, 0);

    // Same color as (0,0) on a mixed board: no writes, three passes
    fill_board(0);
    brd = '{1,1,0, 0,1,4, 1,1,1, 0,0,0, 0,0,0,0};
    load_small(3);
    push_done(0, 0, 6, 46);
    run_move(3, 1, 0);

    // SIZE=0 clamps to a single cell
    fill_board(0);
    brd = '{4,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    load_small(1);
    push_wr(0, 0, 6); push_done(1, 1, 1, 9);
    run_move(0, 6, 0);

    // START pulsed while busy is ignored
    fill_board(7);
    set_test_a(); load_small(2);
    push_small_writes(2, 1); push_done(1, 1, 3, 24);
    run_move(2, 1, 5);

    // Reset during GROW, then an immediate restart on the untouched board
    fill_board(0);
    set_spiral(); load_small(4);
    @(posedge CLOCK); #1;
    SIZE = 5'd4; NEW_COLOR = 3'd5; START = 1'b1;
    @(posedge CLOCK); #1;
    START = 1'b0;
    repeat (9) @(posedge CLOCK);
    #1;
    check("busy_before_abort", int'(BUSY), 1);
    RESET_N = 1'b0;
    @(posedge CLOCK); #1;
    push_small_writes(4, 5); push_done(1, 0, 12, 144);
    RESET_N = 1'b1; START = 1'b1;
    @(negedge CLOCK);
    check("abort_busy", int'(BUSY), 0);
    check("abort_wr_en", int'(WR_EN), 0);
    @(posedge CLOCK); #1;
    START = 1'b0;
    wait_done(0);

    // Full 26x26 uniform board, then SIZE=31 clamped to the same board
    for (int pass = 0; pass < 2; pass++) begin
      fill_board(2);
      for (int r = 0; r < 26; r++)
        for (int c = 0; c < 26; c++)
          push_wr(r, c, 3);
      push_done(1, 1, 676, 2712);
      run_move((pass == 0) ? 26 : 31, 3, 0);
    end

    repeat (3) @(posedge CLOCK);
    check("done_records_left", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1);
  end

endmodule
